// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared encodings and flag decode for the compare result filter
package cmp_pkg;

    localparam logic [1:0] ST_UNKNOWN = 2'b00;
    localparam logic [1:0] ST_EQ      = 2'b01;
    localparam logic [1:0] ST_GT      = 2'b10;
    localparam logic [1:0] ST_LT      = 2'b11;

    typedef struct packed {
        logic       ok;
        logic [1:0] cls;
    } cmp_sample_t;

    // A triple is usable only when exactly one flag is set.
    function automatic cmp_sample_t decode_flags(input logic eq, input logic gt, input logic lt);
        cmp_sample_t s;
        s.ok  = 1'b1;
        s.cls = ST_UNKNOWN;
        case ({eq, gt, lt})
            3'b100:  s.cls = ST_EQ;
            3'b010:  s.cls = ST_GT;
            3'b001:  s.cls = ST_LT;
            default: s.ok  = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter, holds at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/compare_result_filter.sv
// rtl/compare_result_filter.sv - debounce of magnitude comparator flags with entry counters
module compare_result_filter
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE_N = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             A_equal_B,
    input  logic             A_greater_B,
    input  logic             A_less_B,
    input  logic             err_clr,
    output logic [1:0]       stable_state,
    output logic             change_pulse,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             onehot_err
);

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE_N);

    logic [1:0]       candidate, candidate_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic [1:0]       stable_nxt;
    logic             pulse_nxt;
    logic             err_nxt;
    logic             gt_inc, lt_inc;
    cmp_sample_t      sample;

    always_comb begin
        sample        = decode_flags(A_equal_B, A_greater_B, A_less_B);
        candidate_nxt = candidate;
        run_nxt       = run;
        stable_nxt    = stable_state;
        pulse_nxt     = 1'b0;
        err_nxt       = onehot_err;
        gt_inc        = 1'b0;
        lt_inc        = 1'b0;

        if (err_clr) begin
            err_nxt = 1'b0;
        end

        if (in_valid) begin
            if (!sample.ok) begin
                err_nxt = 1'b1;
                run_nxt = '0;
            end else begin
                if ((run != '0) && (sample.cls == candidate)) begin
                    run_nxt = (run == RUN_MAX) ? RUN_MAX : run + 1'b1;
                end else begin
                    candidate_nxt = sample.cls;
                    run_nxt       = 4'd1;
                end
                // Commit on the same edge the run completes, so DEBOUNCE_N=1 is immediate.
                if ((run_nxt == RUN_MAX) && (candidate_nxt != stable_state)) begin
                    stable_nxt = candidate_nxt;
                    pulse_nxt  = 1'b1;
                    gt_inc     = (candidate_nxt == ST_GT);
                    lt_inc     = (candidate_nxt == ST_LT);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate    <= ST_UNKNOWN;
            run          <= '0;
            stable_state <= ST_UNKNOWN;
            change_pulse <= 1'b0;
            onehot_err   <= 1'b0;
        end else begin
            candidate    <= candidate_nxt;
            run          <= run_nxt;
            stable_state <= stable_nxt;
            change_pulse <= pulse_nxt;
            onehot_err   <= err_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_gt_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (gt_inc),
        .count (gt_count)
    );

    sat_counter #(.W(CNT_W)) u_lt_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lt_inc),
        .count (lt_count)
    );

endmodule

// File: tb/tb_compare_result_filter.sv
// tb/tb_compare_result_filter.sv - self-checking bench for compare_result_filter
module tb_compare_result_filter;

    localparam int N     = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [2:0] F_EQ  = 3'b100;
    localparam logic [2:0] F_GT  = 3'b010;
    localparam logic [2:0] F_LT  = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_BAD = 3'b110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             A_equal_B, A_greater_B, A_less_B;
    logic             err_clr;
    logic [1:0]       stable_state;
    logic             change_pulse;
    logic [CNT_W-1:0] gt_count, lt_count;
    logic             onehot_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: remember the valid classes seen since the last invalid sample or reset.
    int m_hist[$];
    int m_stable, m_pulse, m_gt, m_lt, m_err;

    always #5 clk = ~clk;

    compare_result_filter #(.DEBOUNCE_N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .A_equal_B    (A_equal_B),
        .A_greater_B  (A_greater_B),
        .A_less_B     (A_less_B),
        .err_clr      (err_clr),
        .stable_state (stable_state),
        .change_pulse (change_pulse),
        .gt_count     (gt_count),
        .lt_count     (lt_count),
        .onehot_err   (onehot_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".stable"}, {30'd0, stable_state}, m_stable);
        chk({tag, ".pulse"},  {31'd0, change_pulse}, m_pulse);
        chk({tag, ".gt"},     {28'd0, gt_count},     m_gt);
        chk({tag, ".lt"},     {28'd0, lt_count},     m_lt);
        chk({tag, ".err"},    {31'd0, onehot_err},   m_err);
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_stable = 0; m_pulse = 0; m_gt = 0; m_lt = 0; m_err = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] f, input logic c);
        int  ones;
        int  cls;
        bit  same;
        bit  bad;
        ones = int'(f[2]) + int'(f[1]) + int'(f[0]);
        bad  = v && (ones != 1);
        m_pulse = 0;
        if (c) m_err = 0;
        if (bad) begin
            m_err = 1;
            m_hist.delete();
        end else if (v) begin
            cls = f[2] ? 1 : (f[1] ? 2 : 3);
            m_hist.push_back(cls);
            if (m_hist.size() > N) void'(m_hist.pop_front());
            same = (m_hist.size() == N);
            foreach (m_hist[i]) if (m_hist[i] != cls) same = 0;
            if (same && cls != m_stable) begin
                m_stable = cls;
                m_pulse  = 1;
                if (cls == 2 && m_gt < CMAX) m_gt++;
                if (cls == 3 && m_lt < CMAX) m_lt++;
            end
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [2:0] f, input logic c);
        in_valid    = v;
        A_equal_B   = f[2];
        A_greater_B = f[1];
        A_less_B    = f[0];
        err_clr     = c;
        @(posedge clk);
        model_step(v, f, c);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
        A_equal_B = 1'b0; A_greater_B = 1'b0; A_less_B = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three GT samples commit GT on the third edge.
        step("gt3a", 1, F_GT, 0);
        step("gt3b", 1, F_GT, 0);
        step("gt3c", 1, F_GT, 0);
        chk("gt3.stable_const", {30'd0, stable_state}, 2);
        chk("gt3.pulse_const",  {31'd0, change_pulse}, 1);
        chk("gt3.gtcnt_const",  {28'd0, gt_count}, 1);
        step("gt3_hold", 1, F_GT, 0);
        chk("gt3.no_repeat_pulse", {31'd0, change_pulse}, 0);
        step("idle", 0, F_LT, 0);

        // An interleaved LT restarts the run.
        do_reset("rst2");
        step("mix1", 1, F_GT, 0);
        step("mix2", 1, F_GT, 0);
        step("mix3", 1, F_LT, 0);
        step("mix4", 1, F_GT, 0);
        step("mix5", 1, F_GT, 0);
        chk("mix5.no_pulse", {31'd0, change_pulse}, 0);
        step("mix6", 1, F_GT, 0);
        chk("mix6.pulse_const", {31'd0, change_pulse}, 1);

        // Non-one-hot triple breaks the run and latches the error.
        do_reset("rst3");
        step("bad1", 1, F_GT, 0);
        step("bad2", 1, F_GT, 0);
        step("bad3", 1, F_BAD, 0);
        step("bad4", 1, F_GT, 0);
        chk("bad4.stable_const", {30'd0, stable_state}, 0);
        chk("bad4.err_const",    {31'd0, onehot_err}, 1);
        step("bad5", 1, F_GT, 0);
        step("bad6", 1, F_GT, 0);
        chk("bad6.stable_const", {30'd0, stable_state}, 2);

        // Set beats clear, then a clear with a valid sample drops the flag.
        step("clr1", 1, F_NONE, 1);
        chk("clr1.err_const", {31'd0, onehot_err}, 1);
        step("clr2", 1, F_GT, 1);
        chk("clr2.err_const", {31'd0, onehot_err}, 0);

        // Counter saturation: 20 entries each into GT and LT.
        do_reset("rst4");
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 3; j++) step("sat_gt", 1, F_GT, 0);
            for (int j = 0; j < 3; j++) step("sat_lt", 1, F_LT, 0);
        end
        chk("sat.gt_const", {28'd0, gt_count}, 15);
        chk("sat.lt_const", {28'd0, lt_count}, 15);

        // Reset in the middle of an EQ run discards it.
        do_reset("rst5");
        step("eq1", 1, F_EQ, 0);
        step("eq2", 1, F_EQ, 0);
        do_reset("rst_mid");
        step("eq3", 1, F_EQ, 0);
        chk("eq3.pulse_const",  {31'd0, change_pulse}, 0);
        chk("eq3.stable_const", {30'd0, stable_state}, 0);

        // Randomized traffic biased toward runs of the same class.
        begin
            logic [2:0] f;
            logic [2:0] last;
            last = F_GT;
            for (int k = 0; k < 400; k++) begin
                case ($urandom_range(0, 9))
                    0:       f = 3'($urandom_range(0, 7));
                    1, 2:    begin
                                 case ($urandom_range(0, 2))
                                     0: last = F_EQ;
                                     1: last = F_GT;
                                     default: last = F_LT;
                                 endcase
                                 f = last;
                             end
                    default: f = last;
                endcase
                step("rand", ($urandom_range(0, 5) != 0), f, ($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
